// File: rtl/spi_dac_pkg.sv
// Shared definitions for the SPI DAC arbiter: FSM encoding, default
// parameter values and a small index-width helper.
package spi_dac_pkg;

  localparam int N_REQ_DEF       = 4;
  localparam int DW_DEF          = 12;
  localparam int START_HOLD_DEF  = 24;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_COMPLETE  = 2'd3
  } state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the requester
// after last_winner_i, wrapping from N_REQ-1 back to 0.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    last_winner_i,
  output logic             valid_o,
  output logic [IW-1:0]    winner_o
);

  // First asserted request found when scanning last_winner+1, +2, ... modulo N_REQ.
  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_winner_i) + k) % N_REQ;
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_dac_arbiter.sv
// Shares one SPI DAC transmitter among N_REQ requesters. A round-robin
// winner's word is latched, spi_start is held for START_HOLD cycles, then
// the block waits for a rising edge on spi_done (or a timeout) and acks.
module spi_dac_arbiter
  import spi_dac_pkg::*;
#(
  parameter  int N_REQ       = N_REQ_DEF,
  parameter  int DW          = DW_DEF,
  parameter  int START_HOLD  = START_HOLD_DEF,
  parameter  int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int IW          = idx_width(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*DW-1:0] din_bus,
  output logic [N_REQ-1:0]  ack,
  output logic              spi_start,
  output logic [DW-1:0]     spi_din,
  input  logic              spi_done,
  output logic              busy,
  output logic [IW-1:0]     gnt_id,
  output logic              timeout_err
);

  localparam int HW = $clog2(START_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   din_q, din_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            tflag_q, tflag_d;
  logic            done_s_q, done_prev_q;
  logic            done_rise;
  logic            arb_valid;
  logic [IW-1:0]   arb_winner;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .req_i         (req),
    .last_winner_i (last_q),
    .valid_o       (arb_valid),
    .winner_o      (arb_winner)
  );

  // spi_done is registered once and then compared with its previous
  // registered value, so a level that is already high never looks like an edge.
  assign done_rise = done_s_q & ~done_prev_q;

  assign spi_din = din_q;
  assign gnt_id  = gnt_q;

  // Next-state and Moore outputs for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    hold_d      = hold_q;
    tmo_d       = tmo_q;
    tflag_d     = tflag_q;
    spi_start   = 1'b0;
    busy        = 1'b1;
    ack         = '0;
    timeout_err = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (arb_valid) begin
          din_d   = din_bus[int'(arb_winner)*DW +: DW];
          gnt_d   = arb_winner;
          hold_d  = '0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        spi_start = 1'b1;
        if (hold_q == HW'(START_HOLD - 1)) begin
          hold_d  = '0;
          tmo_d   = '0;
          tflag_d = 1'b0;
          state_d = ST_WAIT_DONE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      ST_WAIT_DONE: begin
        // A real edge wins over a timeout expiring in the same cycle.
        if (done_rise) begin
          tmo_d   = '0;
          tflag_d = 1'b0;
          state_d = ST_COMPLETE;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          tmo_d   = '0;
          tflag_d = 1'b1;
          state_d = ST_COMPLETE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_COMPLETE: begin
        ack[gnt_q]  = 1'b1;
        timeout_err = tflag_q;
        last_d      = gnt_q;
        tflag_d     = 1'b0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and edge-detector registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      din_q       <= '0;
      gnt_q       <= '0;
      last_q      <= IW'(N_REQ - 1);
      hold_q      <= '0;
      tmo_q       <= '0;
      tflag_q     <= 1'b0;
      done_s_q    <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      din_q       <= din_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      tflag_q     <= tflag_d;
      done_s_q    <= spi_done;
      done_prev_q <= done_s_q;
    end
  end

endmodule
